soc_riscv_noc_terminator: RTL and testbench
===========================================

SOC_RISCV_NOC_TERMINATOR -- requirements
Module: soc_riscv_noc_terminator

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent NoC virtual channels terminated.
REQ-002 SHALL have parameter FLIT_WIDTH, default 34: flit width in bits.
REQ-003 SHALL have parameter DEPTH, default 4: loopback FIFO entries per channel; power of two, at least 2.
REQ-004 SHALL have port clk  input  1: single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous reset, active low.
REQ-006 SHALL have port in_flit  input  CHANNELS x FLIT_WIDTH: flits arriving from the tile's NoC output.
REQ-007 SHALL have port in_last  input  CHANNELS: last flit of packet.
REQ-008 SHALL have port in_valid  input  CHANNELS: flit valid.
REQ-009 SHALL have port in_ready  output  CHANNELS: flit accepted this cycle when in_valid and in_ready are both high.
REQ-010 SHALL have port loop_en  input  CHANNELS: 1 selects loopback for the next packet; 0 selects sink.
REQ-011 SHALL have port out_flit  output  CHANNELS x FLIT_WIDTH: returned flits toward the tile's NoC input.
REQ-012 SHALL have port out_last  output  CHANNELS: last flit of the returned packet.
REQ-013 SHALL have port out_valid  output  CHANNELS: returned flit valid.
REQ-014 SHALL have port out_ready  input  CHANNELS: tile accepts the returned flit.
REQ-015 SHALL have port pkt_in_cnt  output  CHANNELS x 16: packets accepted per channel.
REQ-016 SHALL have port pkt_out_cnt  output  CHANNELS x 16: packets returned per channel.

Function
REQ-017 SHALL implement per channel a packet FSM with states IDLE, SINK and LOOP; channels are fully independent.
REQ-018 SHALL sample loop_en only in IDLE on an accepted flit; changes to loop_en mid-packet SHALL be ignored.
REQ-019 In IDLE, in_ready SHALL equal 1 when loop_en is 0, and NOT fifo_full when loop_en is 1.
REQ-020 In SINK, in_ready SHALL equal 1, and accepted flits SHALL be discarded.
REQ-021 In LOOP, in_ready SHALL equal NOT fifo_full, and accepted flits with their last bit SHALL be written to the channel FIFO.
REQ-022 On an accepted flit in IDLE, the FSM SHALL stay in IDLE if in_last is 1, otherwise go to LOOP (loop_en=1) or SINK (loop_en=0).
REQ-023 From SINK or LOOP, the FSM SHALL return to IDLE on an accepted flit with in_last=1.
REQ-024 The FIFO SHALL be first-word-fall-through: a flit written at edge N SHALL be presented on out_flit/out_last with out_valid=1 after edge N, i.e. one-cycle latency.
REQ-025 out_valid SHALL equal NOT fifo_empty; a pop SHALL occur on out_valid AND out_ready.
REQ-026 Full FIFO with a simultaneous pop: in_ready SHALL remain 0 that cycle, with no write-through.
REQ-027 Empty FIFO with a simultaneous write: out_valid SHALL be 0 that cycle.
REQ-028 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.
REQ-029 FIFO pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the extra MSB SHALL distinguish full from empty.
REQ-030 out_flit SHALL be 0 when out_valid is 0.

Reset
REQ-031 While rst_n is low, all outputs SHALL be 0 (in_ready, out_valid, out_flit, out_last, counters) and every FSM SHALL be in IDLE.
REQ-032 Reset mid-packet SHALL discard FIFO contents and the partial packet, and clear all pointers.
REQ-033 In the first cycle after rst_n rises, in_ready SHALL follow REQ-019.

Configuration
REQ-034 Macro SOC_NOC_TERM_STATS_EN defined: pkt_in_cnt SHALL increment on each accepted flit with in_last=1 (sink or loop), and pkt_out_cnt on each popped flit with out_last=1; both are 16-bit and wrap 0xFFFF to 0x0000.
REQ-035 Macro SOC_NOC_TERM_STATS_EN undefined: counter registers SHALL be absent, and pkt_in_cnt and pkt_out_cnt SHALL be tied to 0.

Verification
REQ-036 Channel 0, loop_en=0: 3-flit packet with flits 0x1, 0x2, 0x3 -> in_ready=1 every cycle, out_valid stays 0, pkt_in_cnt[0]=1 with stats enabled.
REQ-037 Channel 1, loop_en=1, out_ready=1: 2-flit packet 0xA, 0xB -> out_flit 0xA then 0xB one cycle after each input, out_last on 0xB, pkt_out_cnt[1]=1.
REQ-038 DEPTH=4, loop_en=1, out_ready=0: 6-flit packet -> 4 flits accepted, then in_ready=0; raising out_ready with in_valid held high -> in_ready=0 in the full cycle, then the remaining 2 flits are accepted in order.
REQ-039 Channel 0, loop_en=1: toggle loop_en to 0 after the first flit -> the whole packet is still looped; the next packet is sunk.
REQ-040 Reset mid-packet: assert rst_n=0 with 2 flits in the FIFO -> out_valid=0 and counters=0 immediately; after release, a new 1-flit packet loops correctly.
REQ-041 Stats wrap: 65536 single-flit sunk packets -> pkt_in_cnt returns to 0x0000; with the macro undefined, the counter stays 0 throughout.

Source files
------------

// File: rtl/soc_riscv_noc_terminator.sv
// NoC terminator: per-channel packet FSM that sinks packets or loops them back through a FWFT FIFO.
// Define SOC_NOC_TERM_STATS_EN to build the per-channel packet in/out counters; otherwise they read 0.
module soc_riscv_noc_terminator #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 34,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
    input  logic [CHANNELS-1:0]            in_last,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    input  logic [CHANNELS-1:0]            loop_en,
    output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]            out_last,
    output logic [CHANNELS-1:0]            out_valid,
    input  logic [CHANNELS-1:0]            out_ready,
    output logic [CHANNELS*16-1:0]         pkt_in_cnt,
    output logic [CHANNELS*16-1:0]         pkt_out_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SINK = 2'd1,
        ST_LOOP = 2'd2
    } state_e;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        state_e                state_q, state_d;
        logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
        logic [FLIT_WIDTH:0]   mem_q [DEPTH];
        logic [FLIT_WIDTH:0]   rd_word;
        logic [FLIT_WIDTH-1:0] flit_in;
        logic                  fifo_full, fifo_empty;
        logic                  rdy, loop_sel, accept, wr_en, pop;

        assign flit_in    = in_flit[ch*FLIT_WIDTH +: FLIT_WIDTH];
        assign fifo_empty = (wr_ptr_q == rd_ptr_q);
        // Same slot index with differing wrap bit means the writer is a full lap ahead.
        assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_q <= ST_IDLE;
            else        state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            if (accept) begin
                case (state_q)
                    ST_IDLE: if (!in_last[ch]) state_d = loop_en[ch] ? ST_LOOP : ST_SINK;
                    default: if (in_last[ch])  state_d = ST_IDLE;
                endcase
            end
        end

        // loop_en only matters while idle; mid-packet the state alone decides the path.
        always_comb begin
            rdy      = 1'b0;
            loop_sel = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rdy      = loop_en[ch] ? !fifo_full : 1'b1;
                    loop_sel = loop_en[ch];
                end
                ST_SINK: rdy = 1'b1;
                ST_LOOP: begin
                    rdy      = !fifo_full;
                    loop_sel = 1'b1;
                end
                default: rdy = 1'b0;
            endcase
            rdy = rdy & rst_n;
        end

        assign accept = in_valid[ch] & rdy;
        assign wr_en  = accept & loop_sel;
        assign pop    = !fifo_empty & out_ready[ch];

        assign wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        assign rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {in_last[ch], flit_in};
        end

        assign rd_word       = mem_q[rd_ptr_q[AW-1:0]];
        assign in_ready[ch]  = rdy;
        assign out_valid[ch] = !fifo_empty;
        assign out_last[ch]  = !fifo_empty & rd_word[FLIT_WIDTH];
        assign out_flit[ch*FLIT_WIDTH +: FLIT_WIDTH] =
            fifo_empty ? '0 : rd_word[FLIT_WIDTH-1:0];

`ifdef SOC_NOC_TERM_STATS_EN
        logic [15:0] in_cnt_q, in_cnt_d;
        logic [15:0] out_cnt_q, out_cnt_d;

        assign in_cnt_d  = (accept & in_last[ch]) ? in_cnt_q + 16'd1 : in_cnt_q;
        assign out_cnt_d = (pop & rd_word[FLIT_WIDTH]) ? out_cnt_q + 16'd1 : out_cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                in_cnt_q  <= in_cnt_d;
                out_cnt_q <= out_cnt_d;
            end
        end

        assign pkt_in_cnt[ch*16 +: 16]  = in_cnt_q;
        assign pkt_out_cnt[ch*16 +: 16] = out_cnt_q;
`else
        assign pkt_in_cnt[ch*16 +: 16]  = 16'd0;
        assign pkt_out_cnt[ch*16 +: 16] = 16'd0;
`endif
    end

endmodule

// File: tb/tb_soc_riscv_noc_terminator.sv
// Scoreboard bench for soc_riscv_noc_terminator: packet-level model, directed scenarios, random traffic, counter wrap.
module tb_soc_riscv_noc_terminator;

    localparam int CH = 2;
    localparam int FW = 34;
    localparam int D  = 4;

    logic              clk;
    logic              rst_n;
    logic [CH*FW-1:0]  in_flit;
    logic [CH-1:0]     in_last, in_valid, in_ready, loop_en;
    logic [CH*FW-1:0]  out_flit;
    logic [CH-1:0]     out_last, out_valid, out_ready;
    logic [CH*16-1:0]  pkt_in_cnt, pkt_out_cnt;

    soc_riscv_noc_terminator #(.CHANNELS(CH), .FLIT_WIDTH(FW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .loop_en(loop_en),
        .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Packet-level reference: mode 0 = between packets, 1 = discarding, 2 = returning.
    logic [FW:0]  expq [CH][$];
    int           mode [CH];
    logic [15:0]  in_cnt [CH];
    logic [15:0]  out_cnt [CH];

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d actual=%0h expected=%0h at %0t", name, c, act, exp, $time);
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            mode[c] = 0; in_cnt[c] = '0; out_cnt[c] = '0;
        end
    end

    // Monitor: compare outputs against the model, pop on each returned-flit handshake.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            int          occ;
            logic        exp_rdy;
            logic [FW:0] w;
            logic [15:0] ei, eo;
            if (!rst_n) begin
                chk("rst_in_ready", c, 64'(in_ready[c]), 64'd0);
                chk("rst_out_valid", c, 64'(out_valid[c]), 64'd0);
                chk("rst_out_flit", c, 64'(out_flit[c*FW +: FW]), 64'd0);
                chk("rst_out_last", c, 64'(out_last[c]), 64'd0);
                chk("rst_pkt_in_cnt", c, 64'(pkt_in_cnt[c*16 +: 16]), 64'd0);
                chk("rst_pkt_out_cnt", c, 64'(pkt_out_cnt[c*16 +: 16]), 64'd0);
                expq[c].delete();
                mode[c] = 0; in_cnt[c] = '0; out_cnt[c] = '0;
            end else begin
                occ = expq[c].size();
                if (mode[c] == 1)      exp_rdy = 1'b1;
                else if (mode[c] == 2) exp_rdy = (occ < D);
                else                   exp_rdy = loop_en[c] ? (occ < D) : 1'b1;
                chk("in_ready", c, 64'(in_ready[c]), 64'(exp_rdy));
                chk("out_valid", c, 64'(out_valid[c]), 64'(occ > 0));
                if (occ > 0) begin
                    w = expq[c][0];
                    chk("out_flit", c, 64'(out_flit[c*FW +: FW]), 64'(w[FW-1:0]));
                    chk("out_last", c, 64'(out_last[c]), 64'(w[FW]));
                end else begin
                    chk("out_flit_idle", c, 64'(out_flit[c*FW +: FW]), 64'd0);
                end
`ifdef SOC_NOC_TERM_STATS_EN
                ei = in_cnt[c]; eo = out_cnt[c];
`else
                ei = 16'd0; eo = 16'd0;
`endif
                chk("pkt_in_cnt", c, 64'(pkt_in_cnt[c*16 +: 16]), 64'(ei));
                chk("pkt_out_cnt", c, 64'(pkt_out_cnt[c*16 +: 16]), 64'(eo));
                if (out_valid[c] && out_ready[c] && occ > 0) begin
                    w = expq[c].pop_front();
                    if (w[FW]) out_cnt[c] = out_cnt[c] + 16'd1;
                end
            end
        end
    end

    // Scoreboard push: record each accepted flit and apply the packet rules.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int c = 0; c < CH; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    logic lp;
                    lp = (mode[c] == 0) ? loop_en[c] : (mode[c] == 2);
                    if (lp) expq[c].push_back({in_last[c], in_flit[c*FW +: FW]});
                    if (in_last[c]) begin
                        mode[c] = 0;
                        in_cnt[c] = in_cnt[c] + 16'd1;
                    end else if (mode[c] == 0) begin
                        mode[c] = loop_en[c] ? 2 : 1;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input logic [FW-1:0] f, input logic last, input logic le);
        int n;
        in_flit[c*FW +: FW] = f;
        in_last[c]  = last;
        loop_en[c]  = le;
        in_valid[c] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready[c]) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL send_timeout ch%0d actual=stalled required=accept", c);
                break;
            end
        end
        cyc();
        in_valid[c] = 1'b0;
        in_last[c]  = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_flit = '0; in_last = '0; in_valid = '0; loop_en = '0; out_ready = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        out_ready = '1;
        cyc();

        // Sink a 3-flit packet on channel 0.
        send(0, 34'h1, 1'b0, 1'b0);
        send(0, 34'h2, 1'b0, 1'b0);
        send(0, 34'h3, 1'b1, 1'b0);
        repeat (2) cyc();

        // Loop a 2-flit packet on channel 1.
        send(1, 34'hA, 1'b0, 1'b1);
        send(1, 34'hB, 1'b1, 1'b1);
        repeat (3) cyc();

        // Backpressure: fill the FIFO, then release the consumer while the producer waits.
        out_ready[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, 34'(32'h100 + i), (i == 5), 1'b1);
            end
            begin
                repeat (10) cyc();
                out_ready[0] = 1'b1;
            end
        join
        repeat (6) cyc();

        // loop_en flips mid-packet: packet still looped, next one sunk.
        send(0, 34'h21, 1'b0, 1'b1);
        send(0, 34'h22, 1'b0, 1'b0);
        send(0, 34'h23, 1'b1, 1'b0);
        send(0, 34'h31, 1'b0, 1'b0);
        send(0, 34'h32, 1'b1, 1'b0);
        repeat (4) cyc();

        // Reset with two flits parked in the FIFO, then a fresh single-flit loop.
        out_ready[0] = 1'b0;
        send(0, 34'h41, 1'b0, 1'b1);
        send(0, 34'h42, 1'b0, 1'b1);
        cyc();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        send(0, 34'h51, 1'b1, 1'b1);
        repeat (3) cyc();

        // Random traffic on all channels.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++) begin
                in_valid[c]  = $urandom_range(0, 3) != 0;
                in_last[c]   = $urandom_range(0, 3) == 0;
                loop_en[c]   = $urandom_range(0, 1) == 1;
                out_ready[c] = $urandom_range(0, 2) != 0;
                in_flit[c*FW +: FW] = {$urandom, $urandom};
            end
            cyc();
        end
        in_valid = '0; in_last = '0; out_ready = '1;
        repeat (20) cyc();

        // Counter wrap: 65536 single-flit sunk packets from a clean reset.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        loop_en[0] = 1'b0;
        in_last[0] = 1'b1;
        in_flit[0 +: FW] = 34'h7;
        in_valid[0] = 1'b1;
        repeat (65536) cyc();
        in_valid[0] = 1'b0;
        in_last[0] = 1'b0;
        @(negedge clk);
        chk("wrap_pkt_in_cnt", 0, 64'(pkt_in_cnt[15:0]), 64'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
